// File: rtl/sync_adder.sv
// sync_adder: registered unsigned adder with an enable and a result-valid flag.
// The sum is WIDTH+1 bits wide, so the carry-out is always kept.
// Reset is synchronous and active-low (rst_n), and is sampled on posedge clk.
// Build option SYNC_ADDER_INPUT_REG_EN adds a stage that registers a, b and
// enable on every edge. This gives 2-cycle latency at full throughput.
// With the option undefined, the adder captures a+b directly with 1-cycle latency.
`default_nettype none

module sync_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum,
  output logic             valid
);

  // Operands and qualifier as seen by the adder (direct or registered)
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_en;

  logic [WIDTH:0]   sum_d,   sum_q;
  logic             valid_d, valid_q;

`ifdef SYNC_ADDER_INPUT_REG_EN
  logic [WIDTH-1:0] a_d,  a_q;
  logic [WIDTH-1:0] b_d,  b_q;
  logic             en_d, en_q;

  // Input stage takes new values on every edge, whether or not enable is high
  always_comb begin
    a_d  = a;
    b_d  = b;
    en_d = enable;
  end

  // Input stage flops; reset clears them so no stale capture follows reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      en_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      en_q <= en_d;
    end
  end

  assign add_a  = a_q;
  assign add_b  = b_q;
  assign add_en = en_q;
`else
  assign add_a  = a;
  assign add_b  = b;
  assign add_en = enable;
`endif

  // Next-state for the result: capture on enable, otherwise hold sum and drop valid
  always_comb begin
    // NOTE: default every output first so no path leaves a value unassigned (no latch).
    sum_d   = sum_q;
    valid_d = 1'b0;
    if (add_en) begin
      sum_d   = {1'b0, add_a} + {1'b0, add_b};
      valid_d = 1'b1;
    end
  end

  // Result flops; synchronous reset has priority over any capture
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop updates from pre-edge values.
    if (!rst_n) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign sum   = sum_q;
  assign valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_adder.sv
// Directed bench for sync_adder (WIDTH=8).
// It checks both build options: with SYNC_ADDER_INPUT_REG_EN defined, each
// expected result appears one step later. A reset step clears the outputs at once.
`timescale 1ns/1ps

module tb_sync_adder;

`ifdef SYNC_ADDER_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] a;
  logic [7:0] b;
  logic [8:0] sum;
  logic       valid;

  int errors = 0;
  int checks = 0;

  // Expected result of the previous step (used when the input stage adds a cycle)
  logic [8:0] prev_sum   = '0;
  logic       prev_valid = 1'b0;

  sync_adder #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .a      (a),
    .b      (b),
    .sum    (sum),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  // One clock step: drive at negedge, sample 1ns after posedge.
  // exp_sum/exp_valid are the 1-cycle-latency results for these inputs.
  task automatic step(input logic r, input logic en, input logic [7:0] va,
                      input logic [7:0] vb, input logic [8:0] exp_sum,
                      input logic exp_valid, input string tag);
    logic [8:0] want_sum;
    logic       want_valid;
    @(negedge clk);
    rst_n  = r;
    enable = en;
    a      = va;
    b      = vb;
    @(posedge clk);
    #1;
    if (!r) begin
      want_sum   = '0;
      want_valid = 1'b0;
      prev_sum   = '0;
      prev_valid = 1'b0;
    end else if (LAT == 1) begin
      want_sum   = exp_sum;
      want_valid = exp_valid;
    end else begin
      want_sum   = prev_sum;
      want_valid = prev_valid;
      prev_sum   = exp_sum;
      prev_valid = exp_valid;
    end
    checks++;
    assert (sum === want_sum) else begin
      errors++;
      $error("FAIL %s sum: observed=%0d expected=%0d", tag, sum, want_sum);
    end
    checks++;
    assert (valid === want_valid) else begin
      errors++;
      $error("FAIL %s valid: observed=%0b expected=%0b", tag, valid, want_valid);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    a      = '0;
    b      = '0;
    //   rst  en  a     b      sum  valid tag
    step(0,   0,  8'd0, 8'd0,  0,   0,    "reset1");
    step(0,   1,  8'd9, 8'd9,  0,   0,    "reset2_prio");
    step(1,   0,  8'd0, 8'd0,  0,   0,    "idle");
    step(1,   1,  8'd15, 8'd25, 40, 1,    "add_15_25");
    step(1,   1,  8'd200, 8'd100, 300, 1, "carry_300");
    step(1,   0,  8'd50, 8'd50, 300, 0,   "hold");
    step(1,   1,  8'd50, 8'd50, 100, 1,   "reenable");
    step(1,   1,  8'd0, 8'd0,  0,   1,    "zero");
    step(1,   1,  8'd255, 8'd255, 510, 1, "max");
    step(1,   0,  8'bx, 8'bx,  510, 0,    "x_disabled");
    step(1,   1,  8'd128, 8'd127, 255, 1, "add_128_127");
    step(0,   1,  8'd7, 8'd7,  0,   0,    "mid_reset");
    step(1,   1,  8'd1, 8'd2,  3,   1,    "post_reset");
    step(1,   0,  8'd4, 8'd4,  3,   0,    "hold2");
    step(1,   0,  8'd0, 8'd0,  3,   0,    "flush");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
